qdec_cabac_regbank: RTL and testbench
=====================================

QDEC_CABAC_REGBANK -- requirements
Module: qdec_cabac_regbank

Interface
REQ-001 SHALL have parameter NUM_CFG, default 6, meaning the number of 32-bit configuration registers (1..32).
REQ-002 SHALL have parameter CFG_MASK, default {6{32'hffffffff}}, meaning a per-register writable-bit mask (unpacked array of NUM_CFG x 32).
REQ-003 SHALL have parameter CFG_BASE, default 12'h010, meaning the byte address of CFG[0]; CFG[i] is at CFG_BASE+4*i.
REQ-004 SHALL have ports: clk input 1, system clock.
REQ-005 rst_n input 1, synchronous active-low reset.
REQ-006 reg_req input t_reg_req_s, register-bus request via the team's shared AXI register front-end.
REQ-007 reg_resp output t_reg_resp_s, register-bus response.
REQ-008 cabac_start output 1, one-cycle decode launch pulse.
REQ-009 cabac_abort output 1, one-cycle abort pulse.
REQ-010 cabac_done input 1, one-cycle completion pulse from the decoder.
REQ-011 cabac_err input 1, one-cycle error pulse from the decoder.
REQ-012 cfg_shadow output NUM_CFG x 32, configuration frozen at launch.
REQ-013 busy output 1, high while a decode is in flight.
REQ-014 irq output 1, level interrupt.

Function
REQ-015 The address map SHALL be: 0x000 CTRL (W; bit0 start, bit1 abort; reads 0), 0x004 STATUS (RO; bit0 busy, bit1 fsm==LAUNCH), 0x008 INT_STATUS (W1C; bit0 done, bit1 err, bit2 start_overrun, bit3 aborted), 0x00C INT_EN (RW, 4 bits), CFG[0..NUM_CFG-1] (RW, masked).
REQ-016 Reads of unmapped addresses SHALL return REG_BAD_DATA; writes to unmapped or RO addresses SHALL be ignored.
REQ-017 A CFG[i] write SHALL store wdata & CFG_MASK[i] one cycle after wr_en, regardless of FSM state.
REQ-018 The FSM SHALL have states IDLE, LAUNCH, RUN.
REQ-019 IDLE -> LAUNCH on a CTRL write with bit0=1; in that same transition cfg_shadow SHALL load all live CFG values.
REQ-020 In LAUNCH cabac_start SHALL be 1 for exactly one cycle, then the FSM SHALL enter RUN.
REQ-021 RUN -> IDLE on cabac_done (set INT_STATUS.done), cabac_err (set .err), or a CTRL abort write (pulse cabac_abort, set .aborted).
REQ-022 If done and err coincide, both bits SHALL be set; if done/err coincide with an abort write, done/err SHALL win and no abort pulse SHALL be issued.
REQ-023 A start write while not IDLE SHALL be ignored and SHALL set INT_STATUS.start_overrun; CTRL with bits 0 and 1 both set SHALL be treated as abort only.
REQ-024 cabac_done/cabac_err while IDLE or LAUNCH SHALL be ignored; an abort in IDLE SHALL be a no-op.
REQ-025 busy SHALL equal (state != IDLE); it SHALL rise the cycle after the start write and fall the cycle after the terminating event.
REQ-026 A hardware set and a W1C of the same INT_STATUS bit in the same cycle SHALL leave the bit set.
REQ-027 irq SHALL be registered |(INT_STATUS & INT_EN), one cycle after the status change.
REQ-028 cfg_shadow SHALL change only on the IDLE->LAUNCH transition.

Reset
REQ-029 On rst_n=0 at a clk edge, all registers, cfg_shadow, INT_STATUS, and INT_EN SHALL clear to 0, the FSM SHALL enter IDLE, and cabac_start, cabac_abort, busy, and irq SHALL be 0.
REQ-030 Reset in LAUNCH or RUN SHALL abandon the decode without issuing cabac_abort.

Structure
REQ-031 Register address constants, the INT_STATUS bit positions, and the FSM state enum SHALL reside in the shared axi_pkg.
REQ-032 No sub-module SHALL be used; the FSM, the register file, and the read mux SHALL be a single module.

Verification
REQ-033 Write CFG[2]=0xFFFFFFFF with CFG_MASK[2]=0x07ffffff, then read it back -> 0x07ffffff.
REQ-034 Program CFG[0]=0x5; write CTRL=1 at cycle N -> cabac_start=1 at N+1 only, cfg_shadow[0]=0x5, busy=1 from N+1; write CFG[0]=0x9 during RUN -> shadow stays 0x5, readback 0x9.
REQ-035 With INT_EN=0x1 in RUN, pulse cabac_done -> busy=0 next cycle, INT_STATUS=0x1, irq=1 one cycle later; W1C 0x1 -> irq=0.
REQ-036 Write CTRL=1 in RUN -> no cabac_start, INT_STATUS bit2=1, FSM stays in RUN.
REQ-037 Write CTRL=2 in the same cycle as cabac_done -> no cabac_abort, INT_STATUS=0x1; CTRL=2 in a later RUN -> cabac_abort pulse, INT_STATUS bit3=1.
REQ-038 Assert rst_n=0 mid-RUN -> busy=0, irq=0, all reads return 0 (CTRL through CFG), and no cabac_abort.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared register front-end types, register map constants and CABAC sequencer state.
package axi_pkg;

   localparam logic [11:0] ADDR_CTRL       = 12'h000;
   localparam logic [11:0] ADDR_STATUS     = 12'h004;
   localparam logic [11:0] ADDR_INT_STATUS = 12'h008;
   localparam logic [11:0] ADDR_INT_EN     = 12'h00C;

   localparam int INT_DONE_BIT    = 0;
   localparam int INT_ERR_BIT     = 1;
   localparam int INT_OVERRUN_BIT = 2;
   localparam int INT_ABORTED_BIT = 3;

   localparam logic [31:0] REG_BAD_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      CABAC_IDLE   = 2'd0,
      CABAC_LAUNCH = 2'd1,
      CABAC_RUN    = 2'd2
   } t_cabac_state_e;

   typedef struct packed {
      logic        wr_en;
      logic        rd_en;
      logic [11:0] addr;
      logic [31:0] wdata;
   } t_reg_req_s;

   // Read data is registered: rvalid/rdata appear the cycle after rd_en.
   typedef struct packed {
      logic        rvalid;
      logic [31:0] rdata;
   } t_reg_resp_s;

endpackage

// File: rtl/qdec_cabac_regbank.sv
// CABAC decode launcher: register file, launch/abort sequencer and interrupt logic.
//   state  | meaning
//   IDLE   | no decode in flight, waiting for CTRL.start
//   LAUNCH | cfg_shadow frozen, cabac_start pulsed this cycle
//   RUN    | decoder working, waiting for done/err/abort
module qdec_cabac_regbank
   import axi_pkg::*;
#(
   parameter int          NUM_CFG            = 6,
   parameter logic [31:0] CFG_MASK [NUM_CFG] = '{default: 32'hFFFF_FFFF},
   parameter logic [11:0] CFG_BASE           = 12'h010
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  t_reg_req_s                reg_req,
   output t_reg_resp_s               reg_resp,
   output logic                      cabac_start,
   output logic                      cabac_abort,
   input  logic                      cabac_done,
   input  logic                      cabac_err,
   output logic [NUM_CFG-1:0][31:0]  cfg_shadow,
   output logic                      busy,
   output logic                      irq
);

   t_cabac_state_e            state_q, state_d;
   logic [NUM_CFG-1:0][31:0]  cfg_q, cfg_d;
   logic [NUM_CFG-1:0][31:0]  shadow_q, shadow_d;
   logic [3:0]                int_status_q, int_status_d;
   logic [3:0]                int_en_q, int_en_d;
   logic                      irq_q, irq_d;
   logic                      abort_q, abort_d;
   logic                      rvalid_q, rvalid_d;
   logic [31:0]               rdata_q, rdata_d;

   logic [11:0]        cfg_off;
   logic [NUM_CFG-1:0] cfg_hit;
   logic               wr_ctrl, start_wr, abort_wr;
   logic [3:0]         hw_set, w1c;
   logic [31:0]        rd_mux;

   assign cfg_off  = reg_req.addr - CFG_BASE;
   assign wr_ctrl  = reg_req.wr_en && (reg_req.addr == ADDR_CTRL);
   // CTRL with both bits set is an abort only.
   assign start_wr = wr_ctrl && reg_req.wdata[0] && !reg_req.wdata[1];
   assign abort_wr = wr_ctrl && reg_req.wdata[1];

   always_comb begin
      for (int i = 0; i < NUM_CFG; i++) begin
         cfg_hit[i] = (cfg_off[1:0] == 2'b00) && (cfg_off[11:2] == 10'(i));
      end
   end

   always_comb begin
      cfg_d    = cfg_q;
      int_en_d = int_en_q;
      w1c      = 4'b0000;
      for (int i = 0; i < NUM_CFG; i++) begin
         if (reg_req.wr_en && cfg_hit[i]) cfg_d[i] = reg_req.wdata & CFG_MASK[i];
      end
      if (reg_req.wr_en && reg_req.addr == ADDR_INT_EN)     int_en_d = reg_req.wdata[3:0];
      if (reg_req.wr_en && reg_req.addr == ADDR_INT_STATUS) w1c      = reg_req.wdata[3:0];
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      abort_d  = 1'b0;
      hw_set   = 4'b0000;
      unique case (state_q)
         CABAC_IDLE: begin
            if (start_wr) begin
               state_d  = CABAC_LAUNCH;
               shadow_d = cfg_q;
            end
         end
         CABAC_LAUNCH: begin
            state_d = CABAC_RUN;
            if (start_wr) hw_set[INT_OVERRUN_BIT] = 1'b1;
         end
         CABAC_RUN: begin
            if (start_wr) hw_set[INT_OVERRUN_BIT] = 1'b1;
            // Decoder completion outranks a simultaneous abort request.
            if (cabac_done || cabac_err) begin
               state_d              = CABAC_IDLE;
               hw_set[INT_DONE_BIT] = cabac_done;
               hw_set[INT_ERR_BIT]  = cabac_err;
            end else if (abort_wr) begin
               state_d                 = CABAC_IDLE;
               abort_d                 = 1'b1;
               hw_set[INT_ABORTED_BIT] = 1'b1;
            end
         end
         default: state_d = CABAC_IDLE;
      endcase
      int_status_d = (int_status_q & ~w1c) | hw_set;
      irq_d        = |(int_status_q & int_en_q);
   end

   always_comb begin
      rd_mux = REG_BAD_DATA;
      unique case (reg_req.addr)
         ADDR_CTRL:       rd_mux = 32'h0;
         ADDR_STATUS:     rd_mux = {30'h0, state_q == CABAC_LAUNCH, state_q != CABAC_IDLE};
         ADDR_INT_STATUS: rd_mux = {28'h0, int_status_q};
         ADDR_INT_EN:     rd_mux = {28'h0, int_en_q};
         default: begin
            for (int i = 0; i < NUM_CFG; i++) begin
               if (cfg_hit[i]) rd_mux = cfg_q[i];
            end
         end
      endcase
      rvalid_d = reg_req.rd_en;
      rdata_d  = reg_req.rd_en ? rd_mux : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= CABAC_IDLE;
         cfg_q        <= '0;
         shadow_q     <= '0;
         int_status_q <= 4'b0000;
         int_en_q     <= 4'b0000;
         irq_q        <= 1'b0;
         abort_q      <= 1'b0;
         rvalid_q     <= 1'b0;
         rdata_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         shadow_q     <= shadow_d;
         int_status_q <= int_status_d;
         int_en_q     <= int_en_d;
         irq_q        <= irq_d;
         abort_q      <= abort_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
      end
   end

   assign cabac_start     = (state_q == CABAC_LAUNCH);
   assign cabac_abort     = abort_q;
   assign busy            = (state_q != CABAC_IDLE);
   assign irq             = irq_q;
   assign cfg_shadow      = shadow_q;
   assign reg_resp.rvalid = rvalid_q;
   assign reg_resp.rdata  = rdata_q;

endmodule

// File: tb/tb_qdec_cabac_regbank.sv
// Directed bench for qdec_cabac_regbank: register map, launch/abort sequencing, interrupts, reset.
module tb_qdec_cabac_regbank;
   import axi_pkg::*;

   localparam int NUM_CFG = 6;

   logic                     clk;
   logic                     rst_n;
   t_reg_req_s               reg_req;
   t_reg_resp_s              reg_resp;
   logic                     cabac_start, cabac_abort, cabac_done, cabac_err;
   logic [NUM_CFG-1:0][31:0] cfg_shadow;
   logic                     busy, irq;

   int passed = 0;
   int total  = 0;

   qdec_cabac_regbank #(
      .NUM_CFG  (NUM_CFG),
      .CFG_MASK ('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h07FF_FFFF,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}),
      .CFG_BASE (12'h010)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .reg_req     (reg_req),
      .reg_resp    (reg_resp),
      .cabac_start (cabac_start),
      .cabac_abort (cabac_abort),
      .cabac_done  (cabac_done),
      .cabac_err   (cabac_err),
      .cfg_shadow  (cfg_shadow),
      .busy        (busy),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      reg_req.wr_en = 1'b1;
      reg_req.addr  = addr;
      reg_req.wdata = data;
      tick();
      reg_req.wr_en = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      reg_req.rd_en = 1'b1;
      reg_req.addr  = addr;
      tick();
      reg_req.rd_en = 1'b0;
      chk({tag, "_rvalid"}, {31'h0, reg_resp.rvalid}, 32'h1);
      chk(tag, reg_resp.rdata, exp);
   endtask

   initial begin
      reg_req    = '0;
      cabac_done = 1'b0;
      cabac_err  = 1'b0;
      rst_n      = 1'b0;
      tick();
      tick();
      chk("rst_busy",   {31'h0, busy},        32'h0);
      chk("rst_irq",    {31'h0, irq},         32'h0);
      chk("rst_start",  {31'h0, cabac_start}, 32'h0);
      chk("rst_abort",  {31'h0, cabac_abort}, 32'h0);
      rst_n = 1'b1;
      tick();

      // masked CFG write and unmapped read
      wr(12'h018, 32'hFFFF_FFFF);
      rd("cfg2_mask", 12'h018, 32'h07FF_FFFF);
      rd("unmapped", 12'h100, 32'hDEAD_BEEF);
      rd("cfg_misaligned", 12'h012, 32'hDEAD_BEEF);
      rd("status_idle", 12'h004, 32'h0);

      // launch: start pulse, shadow capture, busy
      wr(12'h010, 32'h5);
      wr(12'h00C, 32'h1);
      wr(12'h000, 32'h1);
      chk("launch_start", {31'h0, cabac_start}, 32'h1);
      chk("launch_busy",  {31'h0, busy},        32'h1);
      chk("launch_shadow", cfg_shadow[0],       32'h5);
      rd("status_launch", 12'h004, 32'h3);
      chk("run_start_low", {31'h0, cabac_start}, 32'h0);
      wr(12'h010, 32'h9);
      chk("run_shadow_frozen", cfg_shadow[0], 32'h5);
      rd("cfg0_live", 12'h010, 32'h9);

      // start overrun during RUN
      wr(12'h000, 32'h1);
      chk("ovr_no_start", {31'h0, cabac_start}, 32'h0);
      rd("ovr_int", 12'h008, 32'h4);
      rd("ovr_status_run", 12'h004, 32'h1);
      wr(12'h008, 32'h4);
      rd("ovr_cleared", 12'h008, 32'h0);

      // done -> busy drops, irq one cycle after status
      cabac_done = 1'b1;
      tick();
      cabac_done = 1'b0;
      chk("done_busy", {31'h0, busy}, 32'h0);
      chk("done_irq_lag", {31'h0, irq}, 32'h0);
      rd("done_int", 12'h008, 32'h1);
      chk("done_irq", {31'h0, irq}, 32'h1);
      wr(12'h008, 32'h1);
      tick();
      chk("w1c_irq", {31'h0, irq}, 32'h0);

      // err during LAUNCH ignored; done wins over simultaneous abort
      wr(12'h000, 32'h1);
      cabac_err = 1'b1;
      tick();
      cabac_err = 1'b0;
      chk("launch_err_busy", {31'h0, busy}, 32'h1);
      rd("launch_err_int", 12'h008, 32'h0);
      reg_req.wr_en = 1'b1;
      reg_req.addr  = 12'h000;
      reg_req.wdata = 32'h2;
      cabac_done    = 1'b1;
      tick();
      reg_req.wr_en = 1'b0;
      cabac_done    = 1'b0;
      chk("coinc_abort", {31'h0, cabac_abort}, 32'h0);
      chk("coinc_busy",  {31'h0, busy},        32'h0);
      rd("coinc_int", 12'h008, 32'h1);
      wr(12'h008, 32'h1);

      // abort in RUN, then abort in IDLE
      wr(12'h000, 32'h1);
      tick();
      wr(12'h000, 32'h2);
      chk("abort_pulse", {31'h0, cabac_abort}, 32'h1);
      chk("abort_busy",  {31'h0, busy},        32'h0);
      tick();
      chk("abort_one_cycle", {31'h0, cabac_abort}, 32'h0);
      rd("abort_int", 12'h008, 32'h8);
      chk("abort_irq_masked", {31'h0, irq}, 32'h0);
      wr(12'h000, 32'h2);
      chk("idle_abort_noop", {31'h0, cabac_abort}, 32'h0);
      wr(12'h000, 32'h3);
      chk("idle_ctrl3_busy", {31'h0, busy}, 32'h0);
      rd("idle_abort_int", 12'h008, 32'h8);
      wr(12'h008, 32'h8);

      // done and err together
      wr(12'h000, 32'h1);
      tick();
      cabac_done = 1'b1;
      cabac_err  = 1'b1;
      tick();
      cabac_done = 1'b0;
      cabac_err  = 1'b0;
      rd("done_err_int", 12'h008, 32'h3);

      // hardware set beats W1C of the same bit
      wr(12'h000, 32'h1);
      tick();
      reg_req.wr_en = 1'b1;
      reg_req.addr  = 12'h008;
      reg_req.wdata = 32'h3;
      cabac_done    = 1'b1;
      tick();
      reg_req.wr_en = 1'b0;
      cabac_done    = 1'b0;
      rd("set_beats_w1c", 12'h008, 32'h1);

      // reset mid-RUN
      wr(12'h00C, 32'hF);
      wr(12'h000, 32'h1);
      tick();
      tick();
      chk("pre_rst_irq",  {31'h0, irq},  32'h1);
      chk("pre_rst_busy", {31'h0, busy}, 32'h1);
      rst_n = 1'b0;
      tick();
      chk("rst_run_busy",   {31'h0, busy},        32'h0);
      chk("rst_run_irq",    {31'h0, irq},         32'h0);
      chk("rst_run_abort",  {31'h0, cabac_abort}, 32'h0);
      chk("rst_run_shadow", cfg_shadow[0],        32'h0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_abort", {31'h0, cabac_abort}, 32'h0);
      for (int a = 0; a < 4 + NUM_CFG; a++) begin
         rd($sformatf("rst_read_%0h", a * 4), 12'(a * 4), 32'h0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
